// File: rtl/ex_dispatch_pkg.sv
// Shared types and constants for the execute dispatch stage.
package ex_pkg;

   localparam int SIG_W = 20;

   localparam logic [4:0] OP_MUL    = 5'd0;
   localparam logic [4:0] OP_MULH   = 5'd1;
   localparam logic [4:0] OP_MULHSU = 5'd2;
   localparam logic [4:0] OP_MULHU  = 5'd3;
   localparam logic [4:0] OP_DIV    = 5'd4;
   localparam logic [4:0] OP_DIVU   = 5'd5;
   localparam logic [4:0] OP_REM    = 5'd6;
   localparam logic [4:0] OP_REMU   = 5'd7;
   localparam logic [4:0] OP_FADD   = 5'd8;
   localparam logic [4:0] OP_FSUB   = 5'd9;
   localparam logic [4:0] OP_FMUL   = 5'd10;
   localparam logic [4:0] OP_FDIV   = 5'd11;
   localparam logic [4:0] OP_FEQ    = 5'd12;
   localparam logic [4:0] OP_FLT    = 5'd13;
   localparam logic [4:0] OP_FLE    = 5'd14;
   localparam logic [4:0] OP_FSGNJ  = 5'd15;
   localparam logic [4:0] OP_FSGNJN = 5'd16;

   localparam logic [2:0] EXC_NONE    = 3'd0;
   localparam logic [2:0] EXC_ILLEGAL = 3'd2;
   localparam logic [2:0] EXC_TIMEOUT = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

endpackage

// File: rtl/ex_dispatch_if.sv
// Decode, exu and writeback signals of the dispatch stage.
// master: dispatch side; slave: surrounding pipeline and exu.
interface ex_dispatch_if
   import ex_pkg::*;
   #(parameter int TAG_W = 5);

   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_op;
   logic [31:0]      in_src1;
   logic [31:0]      in_src2;
   logic [TAG_W-1:0] in_rd;

   logic [SIG_W-1:0] ex_sig;
   logic [31:0]      ex_src1;
   logic [31:0]      ex_src2;
   logic             ex_out_valid;
   logic [31:0]      ex_result;
   logic [2:0]       ex_exception;
   logic             ex_in_valid;

   logic             wb_valid;
   logic             wb_ready;
   logic [31:0]      wb_result;
   logic [2:0]       wb_exception;
   logic [TAG_W-1:0] wb_rd;

   modport master (
      input  in_valid, in_op, in_src1, in_src2, in_rd,
      input  ex_result, ex_exception, ex_in_valid, wb_ready,
      output in_ready, ex_sig, ex_src1, ex_src2, ex_out_valid,
      output wb_valid, wb_result, wb_exception, wb_rd
   );

   modport slave (
      output in_valid, in_op, in_src1, in_src2, in_rd,
      output ex_result, ex_exception, ex_in_valid, wb_ready,
      input  in_ready, ex_sig, ex_src1, ex_src2, ex_out_valid,
      input  wb_valid, wb_result, wb_exception, wb_rd
   );

endinterface

// File: rtl/ex_op_decode.sv
// Opcode to one-hot exu select; opcodes above OP_FSGNJN are illegal.
module ex_op_decode
   import ex_pkg::*;
(
   input  logic [4:0]       op,
   output logic [SIG_W-1:0] sig,
   output logic             legal
);

   always_comb begin
      legal = (op <= OP_FSGNJN);
      sig   = '0;
      if (legal) sig = SIG_W'(1) << op;
   end

endmodule

// File: rtl/ex_dispatch.sv
// Issue stage in front of the multi-cycle exu.
// Optional WAIT watchdog enabled by EX_WATCHDOG_EN.
module ex_dispatch
   import ex_pkg::*;
   #(parameter int TAG_W   = 5,
     parameter int TIMEOUT = 128)
(
   input  logic          clk,
   input  logic          rst,
   ex_dispatch_if.master io,
   output logic          busy
);

   state_t           state;
   logic [SIG_W-1:0] sig_q;
   logic [31:0]      src1_q;
   logic [31:0]      src2_q;
   logic [TAG_W-1:0] rd_q;
   logic [31:0]      res_q;
   logic [2:0]       exc_q;
   logic [SIG_W-1:0] dec_sig;
   logic             dec_legal;

`ifdef EX_WATCHDOG_EN
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] cnt;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
`endif

   ex_op_decode u_dec (
      .op    (io.in_op),
      .sig   (dec_sig),
      .legal (dec_legal)
   );

   assign io.in_ready     = (state == S_IDLE);
   assign io.ex_out_valid = (state == S_ISSUE);
   assign io.wb_valid     = (state == S_DONE);
   assign busy            = (state != S_IDLE);
   assign io.ex_sig       = sig_q;
   assign io.ex_src1      = src1_q;
   assign io.ex_src2      = src2_q;
   assign io.wb_rd        = rd_q;
   assign io.wb_result    = res_q;
   assign io.wb_exception = exc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         sig_q  <= '0;
         src1_q <= '0;
         src2_q <= '0;
         rd_q   <= '0;
         res_q  <= '0;
         exc_q  <= EXC_NONE;
`ifdef EX_WATCHDOG_EN
         cnt    <= '0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (io.in_valid) begin
                  sig_q  <= dec_sig;
                  src1_q <= io.in_src1;
                  src2_q <= io.in_src2;
                  rd_q   <= io.in_rd;
                  if (dec_legal) begin
                     state <= S_ISSUE;
                  end else begin
                     res_q <= '0;
                     exc_q <= EXC_ILLEGAL;
                     state <= S_DONE;
                  end
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
`ifdef EX_WATCHDOG_EN
               cnt   <= '0;
`endif
            end
            S_WAIT: begin
               // a response in the timeout cycle still wins
               if (io.ex_in_valid) begin
                  res_q <= io.ex_result;
                  exc_q <= io.ex_exception;
                  state <= S_DONE;
               end
`ifdef EX_WATCHDOG_EN
               else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  res_q <= '0;
                  exc_q <= EXC_TIMEOUT;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            S_DONE: begin
               if (io.wb_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
